// File: rtl/stream_fifo_adaptive.sv
// Ready/valid stream FIFO covering every depth: 0 is a wire, 1 a pipeline register,
// 2+ a circular buffer of arbitrary depth with optional fall-through and exact fill level.
module stream_fifo_adaptive #(
  parameter int unsigned Depth       = 8,
  parameter int unsigned DataWidth   = 32,
  parameter bit          FallThrough = 1'b0,
  parameter int unsigned AlmostFull  = (Depth > 0) ? Depth - 1 : 0,
  parameter int unsigned UsageWidth  = (Depth > 0) ? $clog2(Depth + 1) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [DataWidth-1:0]  data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DataWidth-1:0]  data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [UsageWidth-1:0] usage_o,
  output logic                  almost_full_o
);

  // Handshake: a beat transfers on a side exactly in the cycle where its valid and ready are both high.
  localparam int unsigned AfClamp = (AlmostFull < 1) ? 1 : ((AlmostFull > Depth) ? Depth : AlmostFull);

  if (Depth > 65535 || DataWidth == 0) begin : g_bad_params
    $fatal(1, "stream_fifo_adaptive: Depth must be <= 65535 and DataWidth >= 1");
  end

  if (Depth == 0) begin : g_wire
    logic unused_d0;
    assign unused_d0     = ^{clk_i, rst_i, flush_i};
    assign data_o        = data_i;
    assign valid_o       = valid_i;
    assign ready_o       = ready_i;
    assign usage_o       = '0;
    assign almost_full_o = 1'b0;
  end else if (Depth == 1) begin : g_reg
    logic                 valid_q;
    logic [DataWidth-1:0] data_q;
    logic                 push, pop;

    // Accepting while full is allowed when the sink drains the register in the same cycle.
    assign ready_o = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign push    = valid_i && ready_o;
    assign pop     = valid_q && ready_i;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (flush_i) begin
        valid_q <= 1'b0;
      end else if (push) begin
        valid_q <= 1'b1;
        data_q  <= data_i;
      end else if (pop) begin
        valid_q <= 1'b0;
      end
    end

    assign usage_o       = UsageWidth'(valid_q);
    assign almost_full_o = (usage_o >= UsageWidth'(AfClamp));
  end else begin : g_ring
    localparam int unsigned            PtrWidth  = $clog2(Depth);
    localparam logic [PtrWidth-1:0]    LastPtr   = PtrWidth'(Depth - 1);
    localparam logic [UsageWidth-1:0]  FullCount = UsageWidth'(Depth);

    logic [DataWidth-1:0]  mem [Depth];
    logic [PtrWidth-1:0]   wr_ptr, rd_ptr;
    logic [UsageWidth-1:0] count;
    logic                  empty, push, pop, bypass, wr_en, rd_en;

    assign empty   = (count == '0);
    assign ready_o = (count != FullCount);
    assign valid_o = !empty || (FallThrough && valid_i);
    assign data_o  = !empty ? mem[rd_ptr] : (FallThrough ? data_i : '0);
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;
    // A pop while empty can only come from fall-through, so the beat skips storage entirely.
    assign bypass  = empty && push && pop;
    assign wr_en   = push && !bypass;
    assign rd_en   = pop && !bypass;

    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en) wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + PtrWidth'(1);
        if (rd_en) rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + PtrWidth'(1);
        if (wr_en && !rd_en)      count <= count + UsageWidth'(1);
        else if (rd_en && !wr_en) count <= count - UsageWidth'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_i && !flush_i && wr_en) mem[wr_ptr] <= data_i;
    end

    assign usage_o       = count;
    assign almost_full_o = (count >= UsageWidth'(AfClamp));
  end

endmodule

// File: tb/tb_stream_fifo_adaptive.sv
// Directed bench for stream_fifo_adaptive: six depth variants share one stimulus bus; a
// scoreboard queue holds accepted payloads and a monitor checks the selected output stream.
module tb_stream_fifo_adaptive;

  logic       clk = 1'b0;
  logic       rst, flush, valid_in, ready_in;
  logic [7:0] data_in;

  // Index: 0=Depth0, 1=Depth1, 2=Depth3, 3=Depth5, 4=Depth4 fall-through, 5=Depth8
  logic       rdy [6];
  logic       vld [6];
  logic [7:0] dat [6];
  logic       af  [6];
  logic       use0, use1;
  logic [1:0] use3;
  logic [2:0] use5, use4;
  logic [3:0] use8;

  int          sel = 0;
  logic        cur_rdy, cur_vld, cur_af;
  logic [7:0]  cur_dat;
  logic [15:0] cur_use;

  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stream_fifo_adaptive #(.Depth(0), .DataWidth(8)) u_d0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(data_in), .valid_i(valid_in),
    .ready_o(rdy[0]), .data_o(dat[0]), .valid_o(vld[0]), .ready_i(ready_in),
    .usage_o(use0), .almost_full_o(af[0]));
  stream_fifo_adaptive #(.Depth(1), .DataWidth(8)) u_d1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(data_in), .valid_i(valid_in),
    .ready_o(rdy[1]), .data_o(dat[1]), .valid_o(vld[1]), .ready_i(ready_in),
    .usage_o(use1), .almost_full_o(af[1]));
  stream_fifo_adaptive #(.Depth(3), .DataWidth(8)) u_d3 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(data_in), .valid_i(valid_in),
    .ready_o(rdy[2]), .data_o(dat[2]), .valid_o(vld[2]), .ready_i(ready_in),
    .usage_o(use3), .almost_full_o(af[2]));
  stream_fifo_adaptive #(.Depth(5), .DataWidth(8)) u_d5 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(data_in), .valid_i(valid_in),
    .ready_o(rdy[3]), .data_o(dat[3]), .valid_o(vld[3]), .ready_i(ready_in),
    .usage_o(use5), .almost_full_o(af[3]));
  stream_fifo_adaptive #(.Depth(4), .DataWidth(8), .FallThrough(1'b1)) u_d4ft (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(data_in), .valid_i(valid_in),
    .ready_o(rdy[4]), .data_o(dat[4]), .valid_o(vld[4]), .ready_i(ready_in),
    .usage_o(use4), .almost_full_o(af[4]));
  stream_fifo_adaptive #(.Depth(8), .DataWidth(8)) u_d8 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(data_in), .valid_i(valid_in),
    .ready_o(rdy[5]), .data_o(dat[5]), .valid_o(vld[5]), .ready_i(ready_in),
    .usage_o(use8), .almost_full_o(af[5]));

  always_comb begin
    cur_rdy = rdy[sel];
    cur_vld = vld[sel];
    cur_dat = dat[sel];
    cur_af  = af[sel];
    cur_use = '0;
    case (sel)
      0: cur_use = 16'(use0);
      1: cur_use = 16'(use1);
      2: cur_use = 16'(use3);
      3: cur_use = 16'(use5);
      4: cur_use = 16'(use4);
      default: cur_use = 16'(use8);
    endcase
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (sel=%0d, t=%0t)", name, act, exp, sel, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic fl);
    valid_in = v;
    data_in  = d;
    ready_in = r;
    flush    = fl;
    #1;
  endtask

  // Record an accepted payload at the negedge before the edge that transfers it.
  task automatic tick();
    @(negedge clk);
    if (rst || flush) exp_q.delete();
    else if (valid_in && cur_rdy) exp_q.push_back(data_in);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst && !flush && cur_vld && ready_in) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL out_unexpected: got 0x%0h, expected no output (sel=%0d, t=%0t)", cur_dat, sel, $time);
      end else begin
        exp_v = exp_q.pop_front();
        check("out_data", cur_dat, exp_v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    data_in = 8'h00;
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;

    // Depth 3: fill, full backpressure, ordered drain
    sel = 2;
    do_reset();
    drive(1'b1, 8'hA1, 1'b0, 1'b0);
    check("t1_ready_empty", cur_rdy, 1);
    check("t1_usage0", cur_use, 0);
    check("t1_af0", cur_af, 0);
    tick();
    drive(1'b1, 8'hB2, 1'b0, 1'b0);
    check("t1_usage1", cur_use, 1);
    check("t1_af_u1", cur_af, 0);
    tick();
    drive(1'b1, 8'hC3, 1'b0, 1'b0);
    check("t1_usage2", cur_use, 2);
    check("t1_af_u2", cur_af, 1);
    check("t1_ready_u2", cur_rdy, 1);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("t1_usage3", cur_use, 3);
    check("t1_ready_full", cur_rdy, 0);
    check("t1_head", cur_dat, 8'hA1);
    tick();
    check("t1_drain_u2", cur_use, 2);
    check("t1_ready_after_pop", cur_rdy, 1);
    tick();
    check("t1_drain_u1", cur_use, 1);
    tick();
    check("t1_drain_u0", cur_use, 0);
    check("t1_valid_empty", cur_vld, 0);
    check("t1_queue_empty", exp_q.size(), 0);

    // Depth 5: wrap-around with alternating sink ready
    sel = 3;
    do_reset();
    begin
      int i;
      logic acc;
      i = 0;
      for (int k = 0; k < 60; k++) begin
        drive(i < 12, 8'(i), (k % 2) == 0, 1'b0);
        if (k == 8) begin
          check("t2_full_ready", cur_rdy, 0);
          check("t2_full_usage", cur_use, 5);
        end
        acc = (i < 12) && cur_rdy;
        tick();
        if (acc) i++;
        check("t2_usage_le5", (cur_use <= 16'd5), 1);
      end
      check("t2_pushed", i, 12);
    end
    check("t2_final_usage", cur_use, 0);
    check("t2_queue_empty", exp_q.size(), 0);

    // Depth 4 fall-through: bypass, then store, then flush with a concurrent push
    sel = 4;
    do_reset();
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    check("t3_bypass_valid", cur_vld, 1);
    check("t3_bypass_data", cur_dat, 8'h55);
    tick();
    check("t3_bypass_usage", cur_use, 0);
    drive(1'b1, 8'h66, 1'b0, 1'b0);
    check("t3_ft_data", cur_dat, 8'h66);
    tick();
    check("t3_store_usage", cur_use, 1);
    check("t3_store_data", cur_dat, 8'h66);
    drive(1'b1, 8'h67, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h68, 1'b0, 1'b0);
    tick();
    check("t4_usage3", cur_use, 3);
    drive(1'b1, 8'h77, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("t4_flush_usage", cur_use, 0);
    check("t4_flush_valid", cur_vld, 0);
    check("t4_flush_ready", cur_rdy, 1);
    tick();
    tick();
    check("t4_queue_empty", exp_q.size(), 0);

    // Depth 1: full-rate streaming, one stall cycle
    sel = 1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(i), 1'b1, 1'b0);
      check("t5_ready_stream", cur_rdy, 1);
      tick();
      check("t5_latency_data", cur_dat, i);
      check("t5_latency_valid", cur_vld, 1);
    end
    drive(1'b1, 8'h08, 1'b0, 1'b0);
    check("t5_stall_ready", cur_rdy, 0);
    tick();
    check("t5_stall_hold", cur_dat, 8'h07);
    drive(1'b1, 8'h08, 1'b1, 1'b0);
    check("t5_resume_ready", cur_rdy, 1);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    check("t5_final_valid", cur_vld, 0);
    check("t5_final_usage", cur_use, 0);
    check("t5_queue_empty", exp_q.size(), 0);

    // Depth 8: almost-full boundary, full, partial drain, reset mid-stream
    sel = 5;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    check("t6_usage7", cur_use, 7);
    check("t6_af7", cur_af, 1);
    check("t6_ready7", cur_rdy, 1);
    drive(1'b1, 8'h87, 1'b0, 1'b0);
    tick();
    check("t6_usage8", cur_use, 8);
    check("t6_ready8", cur_rdy, 0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    check("t6_usage5", cur_use, 5);
    check("t6_af5", cur_af, 0);
    rst = 1'b1;
    drive(1'b1, 8'h99, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("t6_rst_usage", cur_use, 0);
    check("t6_rst_valid", cur_vld, 0);
    check("t6_rst_ready", cur_rdy, 1);
    check("t6_rst_data", cur_dat, 0);
    check("t6_rst_af", cur_af, 0);

    // Depth 0: pure combinational passthrough
    sel = 0;
    drive(1'b1, 8'h3C, 1'b1, 1'b0);
    check("t6_d0_data", cur_dat, 8'h3C);
    check("t6_d0_valid", cur_vld, 1);
    check("t6_d0_ready", cur_rdy, 1);
    check("t6_d0_usage", cur_use, 0);
    check("t6_d0_af", cur_af, 0);
    tick();
    drive(1'b1, 8'hC3, 1'b0, 1'b0);
    check("t6_d0_ready_low", cur_rdy, 0);
    check("t6_d0_data2", cur_dat, 8'hC3);
    tick();
    drive(1'b0, 8'h12, 1'b1, 1'b0);
    check("t6_d0_valid_low", cur_vld, 0);
    check("t6_d0_data3", cur_dat, 8'h12);
    tick();
    check("t6_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
